// File: rtl/ac_pkg.sv
// ============================================================================
// Module   : ac_pkg
// Purpose  : Shared defaults, FSM encoding and goto-entry type for the
//            Aho-Corasick scan controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ac_pkg;

    localparam int C_SW_DEF       = 8;
    localparam int C_N_ENT_DEF    = 32;
    localparam int C_MAX_FAIL_DEF = 15;
    localparam int C_PW_DEF       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FAIL  = 3'd2,
        ST_FWAIT = 3'd3,
        ST_ACC   = 3'd4,
        ST_AWAIT = 3'd5
    } fsm_e;

    typedef struct packed {
        logic [C_SW_DEF-1:0] cur;
        logic [7:0]          chr;
        logic [C_SW_DEF-1:0] nxt;
    } goto_ent_t;

endpackage

`default_nettype wire

// File: rtl/ac_scan_ctrl_if.sv
// ============================================================================
// Module   : ac_scan_ctrl_if
// Purpose  : Character input, table RAM ports, match report and status of
//            the scan controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ac_scan_ctrl_if #(
    parameter int N_ENT = 32,
    parameter int SW    = 8,
    parameter int PW    = 16
);
    localparam int AW = $clog2(N_ENT);

    logic          chr_valid;
    logic [7:0]    chr_data;
    logic          chr_ready;
    logic [AW-1:0] tbl_addr;
    logic [SW-1:0] tbl_cur;
    logic [7:0]    tbl_chr;
    logic [SW-1:0] tbl_nxt;
    logic [SW-1:0] fa_addr;
    logic [SW-1:0] fa_fail;
    logic          fa_acc;
    logic [SW-1:0] state_out;
    logic          match_valid;
    logic [SW-1:0] match_state;
    logic [PW-1:0] match_pos;
    logic          busy;
    logic          err;

    modport master (
        input  chr_valid, chr_data, tbl_cur, tbl_chr, tbl_nxt, fa_fail, fa_acc,
        output chr_ready, tbl_addr, fa_addr, state_out, match_valid,
               match_state, match_pos, busy, err
    );

    modport slave (
        output chr_valid, chr_data, tbl_cur, tbl_chr, tbl_nxt, fa_fail, fa_acc,
        input  chr_ready, tbl_addr, fa_addr, state_out, match_valid,
               match_state, match_pos, busy, err
    );

endinterface

`default_nettype wire

// File: rtl/ac_goto_scanner.sv
// ============================================================================
// Module   : ac_goto_scanner
// Purpose  : Steps the goto table address and reports the first entry that
//            matches (state, character), or exhaustion of the table.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ac_goto_scanner #(
    parameter int N_ENT = 32,
    parameter int SW    = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_clr,
    input  wire logic                     i_scan,
    input  wire logic [SW-1:0]            i_state,
    input  wire logic [7:0]               i_chr,
    input  wire logic [SW-1:0]            i_tbl_cur,
    input  wire logic [7:0]               i_tbl_chr,
    input  wire logic [SW-1:0]            i_tbl_nxt,
    output logic      [$clog2(N_ENT)-1:0] o_addr,
    output logic                          o_hit,
    output logic                          o_done,
    output logic      [SW-1:0]            o_nxt
);

    localparam int            AW     = $clog2(N_ENT);
    localparam int            CW     = $clog2(N_ENT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_ENT);

    // r_idx counts scan cycles; at r_idx = k the RAM returns entry k-1
    logic [CW-1:0] r_idx;
    logic          w_cmp_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr || !i_scan) begin
            r_idx <= '0;
        end else if (r_idx != C_LAST) begin
            r_idx <= r_idx + CW'(1);
        end
    end

    assign w_cmp_vld = i_scan && (r_idx != '0);
    assign o_hit     = w_cmp_vld && (i_tbl_cur == i_state) && (i_tbl_chr == i_chr);
    assign o_done    = i_scan && (r_idx == C_LAST) && !o_hit;
    assign o_addr    = (i_scan && (r_idx < C_LAST)) ? r_idx[AW-1:0] : '0;
    assign o_nxt     = i_tbl_nxt;

endmodule

`default_nettype wire

// File: rtl/ac_scan_ctrl.sv
// ============================================================================
// Module   : ac_scan_ctrl
// Purpose  : Per-character Aho-Corasick sequencer: goto scan, failure hops,
//            accept lookup and match reporting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ac_scan_ctrl
    import ac_pkg::*;
#(
    parameter int N_ENT    = C_N_ENT_DEF,
    parameter int SW       = C_SW_DEF,
    parameter int MAX_FAIL = C_MAX_FAIL_DEF,
    parameter int PW       = C_PW_DEF
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      en,
    input  wire logic      clr,
    ac_scan_ctrl_if.master bus
);

    localparam int            AW         = $clog2(N_ENT);
    localparam int            HW         = $clog2(MAX_FAIL + 1);
    localparam logic [HW-1:0] C_MAX_HOPS = HW'(MAX_FAIL);

    fsm_e          r_fsm,   w_fsm;
    logic [SW-1:0] r_state, w_state;
    logic [7:0]    r_chr,   w_chr;
    logic [HW-1:0] r_hops,  w_hops;
    logic [PW-1:0] r_pos,   w_pos;
    logic          r_err,   w_err;
    logic          r_mv,    w_mv;
    logic [SW-1:0] r_ms,    w_ms;
    logic [PW-1:0] r_mp,    w_mp;

    logic          w_ready;
    logic          w_hit;
    logic          w_done;
    logic [SW-1:0] w_nxt;
    logic [AW-1:0] w_tbl_addr;

    ac_goto_scanner #(
        .N_ENT (N_ENT),
        .SW    (SW)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (clr),
        .i_scan    (r_fsm == ST_SCAN),
        .i_state   (r_state),
        .i_chr     (r_chr),
        .i_tbl_cur (bus.tbl_cur),
        .i_tbl_chr (bus.tbl_chr),
        .i_tbl_nxt (bus.tbl_nxt),
        .o_addr    (w_tbl_addr),
        .o_hit     (w_hit),
        .o_done    (w_done),
        .o_nxt     (w_nxt)
    );

    assign w_ready = !rst && (r_fsm == ST_IDLE) && en && !clr;

    always_comb begin
        w_fsm   = r_fsm;
        w_state = r_state;
        w_chr   = r_chr;
        w_hops  = r_hops;
        w_pos   = r_pos;
        w_err   = r_err;
        w_mv    = 1'b0;
        w_ms    = '0;
        w_mp    = '0;
        if (clr) begin
            w_fsm   = ST_IDLE;
            w_state = '0;
            w_pos   = '0;
            w_err   = 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (bus.chr_valid && w_ready) begin
                        w_chr  = bus.chr_data;
                        w_hops = '0;
                        w_fsm  = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        w_state = w_nxt;
                        w_fsm   = ST_ACC;
                    end else if (w_done) begin
                        // the root has an implicit self-loop for every character
                        w_fsm = (r_state == '0) ? ST_ACC : ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    if (r_hops == C_MAX_HOPS) begin
                        w_err   = 1'b1;
                        w_state = '0;
                        w_fsm   = ST_ACC;
                    end else begin
                        w_hops = r_hops + HW'(1);
                        w_fsm  = ST_FWAIT;
                    end
                end
                ST_FWAIT: begin
                    w_state = bus.fa_fail;
                    w_fsm   = ST_SCAN;
                end
                ST_ACC: begin
                    w_fsm = ST_AWAIT;
                end
                ST_AWAIT: begin
                    if (bus.fa_acc) begin
                        w_mv = 1'b1;
                        w_ms = r_state;
                        w_mp = r_pos;
                    end
                    w_pos = r_pos + PW'(1);
                    w_fsm = ST_IDLE;
                end
                default: begin
                    w_fsm = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_chr   <= '0;
            r_hops  <= '0;
            r_pos   <= '0;
            r_err   <= 1'b0;
            r_mv    <= 1'b0;
            r_ms    <= '0;
            r_mp    <= '0;
        end else begin
            r_fsm   <= w_fsm;
            r_state <= w_state;
            r_chr   <= w_chr;
            r_hops  <= w_hops;
            r_pos   <= w_pos;
            r_err   <= w_err;
            r_mv    <= w_mv;
            r_ms    <= w_ms;
            r_mp    <= w_mp;
        end
    end

    assign bus.chr_ready   = w_ready;
    assign bus.tbl_addr    = w_tbl_addr;
    assign bus.fa_addr     = ((r_fsm == ST_FAIL) || (r_fsm == ST_ACC)) ? r_state : '0;
    assign bus.state_out   = r_state;
    assign bus.match_valid = r_mv;
    assign bus.match_state = r_ms;
    assign bus.match_pos   = r_mp;
    assign bus.busy        = (r_fsm != ST_IDLE);
    assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ac_scan_ctrl.sv
// ============================================================================
// Module   : tb_ac_scan_ctrl
// Purpose  : Self-checking bench for ac_scan_ctrl with he/she/his/hers tables.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ac_scan_ctrl;
    import ac_pkg::*;

    localparam int N_ENT    = 32;
    localparam int SW       = 8;
    localparam int MAX_FAIL = 15;
    localparam int PW       = 5;  // narrow position counter so the wrap is reachable

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;

    ac_scan_ctrl_if #(.N_ENT(N_ENT), .SW(SW), .PW(PW)) bus ();

    ac_scan_ctrl #(
        .N_ENT    (N_ENT),
        .SW       (SW),
        .MAX_FAIL (MAX_FAIL),
        .PW       (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    goto_ent_t     tbl    [N_ENT];
    logic [SW-1:0] fail_t [256];
    logic          acc_t  [256];
    goto_ent_t     tbl_q;
    logic [SW-1:0] fa_q;
    logic          acc_q;

    always @(posedge clk) begin
        tbl_q <= tbl[bus.tbl_addr];
        fa_q  <= fail_t[bus.fa_addr];
        acc_q <= acc_t[bus.fa_addr];
    end

    assign bus.tbl_cur = tbl_q.cur;
    assign bus.tbl_chr = tbl_q.chr;
    assign bus.tbl_nxt = tbl_q.nxt;
    assign bus.fa_fail = fa_q;
    assign bus.fa_acc  = acc_q;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int st;
        int pos;
    } mt_t;

    int   m_state = 0;
    int   m_pos   = 0;
    int   m_err   = 0;
    mt_t  exp_q[$];
    mt_t  got_log[$];

    function automatic int first_hit(input int s, input int c);
        for (int k = 0; k < N_ENT; k++)
            if (int'(tbl[k].cur) == s && int'(tbl[k].chr) == c) return k;
        return -1;
    endfunction

    // Walk goto/failure from the current state; cyc is the expected BUSY length
    task automatic model_step(input logic [7:0] c, output int cyc);
        int s;
        int hops;
        int k;
        s    = m_state;
        hops = 0;
        cyc  = 0;
        while (1) begin
            k = first_hit(s, int'(c));
            if (k >= 0) begin
                cyc += k + 2;
                s = int'(tbl[k].nxt);
                break;
            end
            cyc += N_ENT + 1;
            if (s == 0) break;
            if (hops == MAX_FAIL) begin
                cyc  += 1;
                m_err = 1;
                s     = 0;
                break;
            end
            hops++;
            cyc += 2;
            s = int'(fail_t[s]);
        end
        cyc += 2;
        m_state = s;
        if (acc_t[s]) exp_q.push_back('{st: s, pos: m_pos});
        m_pos = (m_pos + 1) % (1 << PW);
    endtask

    task automatic model_clear();
        m_state = 0;
        m_pos   = 0;
        m_err   = 0;
        exp_q.delete();
    endtask

    // ---------------- match comparison ----------------
    always @(negedge clk) begin
        if (!rst && bus.match_valid) begin
            got_log.push_back('{st: int'(bus.match_state), pos: int'(bus.match_pos)});
            if (exp_q.size() == 0) begin
                chk("unexpected_match_valid", 32'(bus.match_valid), 32'd0);
            end else begin
                mt_t e;
                e = exp_q.pop_front();
                chk("match_state", 32'(bus.match_state), 32'(e.st));
                chk("match_pos", 32'(bus.match_pos), 32'(e.pos));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_char(input logic [7:0] c, output int st, output int cyc);
        int t;
        int cyc_exp;
        st  = -1;
        cyc = -1;
        @(negedge clk);
        bus.chr_valid = 1'b1;
        bus.chr_data  = c;
        t = 0;
        while (!bus.chr_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.chr_ready) begin
            chk("ready_timeout", 32'(bus.chr_ready), 32'd1);
            bus.chr_valid = 1'b0;
            return;
        end
        model_step(c, cyc_exp);
        @(negedge clk);
        bus.chr_valid = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(cyc), 32'(cyc_exp));
        chk("state_out", 32'(bus.state_out), 32'(m_state));
        chk("err", 32'(bus.err), 32'(m_err));
        st = int'(bus.state_out);
        @(negedge clk);
        chk("match_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_str(input string s);
        int st;
        int cyc;
        for (int i = 0; i < s.len(); i++) send_char(s[i], st, cyc);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    // Launch a character and abandon it a few cycles into its SCAN
    task automatic start_and_hold(input logic [7:0] c);
        @(negedge clk);
        bus.chr_valid = 1'b1;
        bus.chr_data  = c;
        @(negedge clk);
        bus.chr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(bus.chr_ready),   32'd0);
        chk({tag, "_busy"},   32'(bus.busy),        32'd0);
        chk({tag, "_state"},  32'(bus.state_out),   32'd0);
        chk({tag, "_err"},    32'(bus.err),         32'd0);
        chk({tag, "_mv"},     32'(bus.match_valid), 32'd0);
        chk({tag, "_ms"},     32'(bus.match_state), 32'd0);
        chk({tag, "_mp"},     32'(bus.match_pos),   32'd0);
        chk({tag, "_taddr"},  32'(bus.tbl_addr),    32'd0);
        chk({tag, "_faddr"},  32'(bus.fa_addr),     32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        int cyc;
        string alph;

        for (int i = 0; i < N_ENT; i++) tbl[i] = '{cur: 8'hFF, chr: 8'h00, nxt: 8'h00};
        for (int i = 0; i < 256; i++) begin
            fail_t[i] = '0;
            acc_t[i]  = 1'b0;
        end
        tbl[0] = '{cur: 8'd0, chr: "h", nxt: 8'd1};
        tbl[1] = '{cur: 8'd1, chr: "e", nxt: 8'd2};
        tbl[2] = '{cur: 8'd0, chr: "s", nxt: 8'd3};
        tbl[3] = '{cur: 8'd3, chr: "h", nxt: 8'd4};
        tbl[4] = '{cur: 8'd4, chr: "e", nxt: 8'd5};
        tbl[5] = '{cur: 8'd1, chr: "i", nxt: 8'd6};
        tbl[6] = '{cur: 8'd6, chr: "s", nxt: 8'd7};
        tbl[7] = '{cur: 8'd2, chr: "r", nxt: 8'd8};
        tbl[8] = '{cur: 8'd8, chr: "s", nxt: 8'd9};
        fail_t[4] = 8'd1;
        fail_t[5] = 8'd2;
        fail_t[7] = 8'd3;
        fail_t[9] = 8'd3;
        acc_t[2] = 1'b1;
        acc_t[5] = 1'b1;
        acc_t[7] = 1'b1;
        acc_t[9] = 1'b1;

        bus.chr_valid = 1'b0;
        bus.chr_data  = '0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.chr_ready), 32'd1);

        // 1: "ushers"
        got_log.delete();
        send_str("ushers");
        chk("ushers_nmatch", 32'(got_log.size()), 32'd2);
        if (got_log.size() == 2) begin
            chk("ushers_m0_state", 32'(got_log[0].st), 32'd5);
            chk("ushers_m0_pos",   32'(got_log[0].pos), 32'd3);
            chk("ushers_m1_state", 32'(got_log[1].st), 32'd9);
            chk("ushers_m1_pos",   32'(got_log[1].pos), 32'd5);
        end
        chk("ushers_final_state", 32'(bus.state_out), 32'd9);

        // 2: "his"
        pulse_clr();
        got_log.delete();
        send_char("h", st, cyc);
        chk("his_trace0", 32'(st), 32'd1);
        send_char("i", st, cyc);
        chk("his_trace1", 32'(st), 32'd6);
        send_char("s", st, cyc);
        chk("his_trace2", 32'(st), 32'd7);
        chk("his_nmatch", 32'(got_log.size()), 32'd1);
        if (got_log.size() == 1) begin
            chk("his_m_state", 32'(got_log[0].st), 32'd7);
            chk("his_m_pos",   32'(got_log[0].pos), 32'd2);
        end

        // 3: 'x' at root: full scan, no hop, ACC+AWAIT
        pulse_clr();
        send_char("x", st, cyc);
        chk("x_state", 32'(st), 32'd0);
        chk("x_busy_literal", 32'(cyc), 32'(N_ENT + 3));

        // 4: self-referencing failure link 4->4 exhausts the hop budget
        fail_t[4] = 8'd4;
        pulse_clr();
        got_log.delete();
        send_char("s", st, cyc);
        send_char("h", st, cyc);
        send_char("z", st, cyc);
        chk("loop_err", 32'(bus.err), 32'd1);
        chk("loop_state", 32'(st), 32'd0);
        chk("loop_busy_literal", 32'(cyc), 32'(16 * (N_ENT + 1) + 15 * 2 + 1 + 2));
        send_char("h", st, cyc);
        chk("err_sticky", 32'(bus.err), 32'd1);
        pulse_clr();
        chk("err_cleared", 32'(bus.err), 32'd0);
        fail_t[4] = 8'd1;

        // 5: RST then CLR while 'e' of "she" is being scanned
        send_str("sh");
        start_and_hold("e");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_abort");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        got_log.delete();
        send_str("sh");
        start_and_hold("e");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk_all_zero("clr_abort");
        clr = 1'b0;
        model_clear();
        #1;
        chk("ready_after_clr", 32'(bus.chr_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("abort_no_match", 32'(got_log.size()), 32'd0);

        // 6: EN low stalls the handshake and the table
        @(negedge clk);
        en = 1'b0;
        bus.chr_valid = 1'b1;
        bus.chr_data  = "h";
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("en0_ready", 32'(bus.chr_ready), 32'd0);
            chk("en0_busy", 32'(bus.busy), 32'd0);
            chk("en0_taddr", 32'(bus.tbl_addr), 32'd0);
        end
        bus.chr_valid = 1'b0;
        en = 1'b1;
        pulse_clr();
        for (int i = 0; i < (1 << PW) - 1; i++) send_char("x", st, cyc);
        got_log.delete();
        send_str("he");
        chk("wrap_nmatch", 32'(got_log.size()), 32'd1);
        if (got_log.size() == 1) begin
            chk("wrap_m_state", 32'(got_log[0].st), 32'd2);
            chk("wrap_m_pos",   32'(got_log[0].pos), 32'd0);
        end

        // Random streams with occasional clears and EN stalls
        alph = "hesirxu";
        pulse_clr();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 29) == 0) pulse_clr();
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                en = 1'b0;
                bus.chr_valid = 1'b1;
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    chk("rnd_en0_ready", 32'(bus.chr_ready), 32'd0);
                end
                bus.chr_valid = 1'b0;
                en = 1'b1;
            end
            send_char(alph[$urandom_range(0, 6)], st, cyc);
        end
        repeat (3) @(negedge clk);
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
